// File: rtl/snn_seq_pkg.sv
// Shared types and defaults for the SNN inference sequencer.
package snn_seq_pkg;

    typedef enum logic [1:0] {IDLE, RESET, SETTLE, DONE} seq_state_t;

    localparam int SNN_SETTLE_DEFAULT = 25;
    localparam int SNN_RST_DEFAULT    = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/snn_window_counter.sv
// Loadable down counter that times both the network-reset and settle windows.
module snn_window_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Parks at zero once expired, so an idle counter reads as expired.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/snn_inference_sequencer.sv
// Runs one reset/settle/sample inference on the XOR SNN per accepted request.
// Optional feature macro SNN_SEQ_SPIKE_COUNT_EN adds a spike counter and threshold decision.
module snn_inference_sequencer
    import snn_seq_pkg::*;
#(
    parameter int INT_WIDTH     = 4,
    parameter int RST_CYCLES    = SNN_RST_DEFAULT,
    parameter int SETTLE_CYCLES = SNN_SETTLE_DEFAULT,
    parameter int SPIKE_THRESH  = 1,
    parameter int CNT_WIDTH     = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_in1,
    input  logic req_in2,
    output logic net_rst,
    output logic net_in1,
    output logic net_in2,
    input  logic net_out,
    output logic res_valid,
    input  logic res_ready,
    output logic res_out
`ifdef SNN_SEQ_SPIKE_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] res_spike_count
`endif
);

    localparam int WIN_WIDTH = $clog2(max_int(RST_CYCLES, SETTLE_CYCLES) + 1);

    if (RST_CYCLES < 1) begin : g_bad_rst_cycles
        $error("RST_CYCLES must be at least 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle_cycles
        $error("SETTLE_CYCLES must be at least 1");
    end
    if (INT_WIDTH < 1 || CNT_WIDTH < 1 || SPIKE_THRESH < 0) begin : g_bad_widths
        $error("INT_WIDTH and CNT_WIDTH must be positive, SPIKE_THRESH non-negative");
    end

    seq_state_t           state;
    logic                 accept;
    logic                 win_load;
    logic [WIN_WIDTH-1:0] win_load_val;
    logic                 win_expired;

    assign accept = req_valid && req_ready;

    always_comb begin
        win_load     = 1'b0;
        win_load_val = '0;
        case (state)
            IDLE: begin
                win_load     = accept;
                win_load_val = WIN_WIDTH'(RST_CYCLES - 1);
            end
            RESET: begin
                win_load     = win_expired;
                win_load_val = WIN_WIDTH'(SETTLE_CYCLES - 1);
            end
            default: ;
        endcase
    end

    snn_window_counter #(
        .WIDTH(WIN_WIDTH)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .load    (win_load),
        .load_val(win_load_val),
        .expired (win_expired)
    );

`ifdef SNN_SEQ_SPIKE_COUNT_EN
    logic [CNT_WIDTH-1:0] spike_cnt;
    logic [CNT_WIDTH-1:0] spike_next;

    // Includes the current cycle so the DONE-entry value counts the last SETTLE cycle.
    always_comb begin
        spike_next = spike_cnt;
        if (net_out && (spike_cnt != '1)) begin
            spike_next = spike_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            net_rst   <= 1'b1;
            net_in1   <= 1'b0;
            net_in2   <= 1'b0;
            res_valid <= 1'b0;
            res_out   <= 1'b0;
`ifdef SNN_SEQ_SPIKE_COUNT_EN
            spike_cnt       <= '0;
            res_spike_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= RESET;
                        req_ready <= 1'b0;
                        net_rst   <= 1'b1;
                        net_in1   <= req_in1;
                        net_in2   <= req_in2;
                    end
                end
                RESET: begin
                    if (win_expired) begin
                        state   <= SETTLE;
                        net_rst <= 1'b0;
`ifdef SNN_SEQ_SPIKE_COUNT_EN
                        spike_cnt <= '0;
`endif
                    end
                end
                SETTLE: begin
`ifdef SNN_SEQ_SPIKE_COUNT_EN
                    spike_cnt <= spike_next;
`endif
                    if (win_expired) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
`ifdef SNN_SEQ_SPIKE_COUNT_EN
                        res_spike_count <= spike_next;
                        res_out         <= (int'(spike_next) >= SPIKE_THRESH);
`else
                        res_out <= net_out;
`endif
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        req_ready <= 1'b1;
                        net_rst   <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    net_rst   <= 1'b1;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
